// File: rtl/shift_sequencer.sv
// Sequencer that drives the mode-select, serial-in and parallel-load lines of an
// external shift register. The register samples on the falling clk edge, so each
// registered cycle of s is captured exactly once.
//
// Ports:
//   clk      - clock; all state updates on the rising edge
//   reset    - asynchronous active-low reset
//   start    - command strobe, accepted only in IDLE
//   cmd      - 00 nop, 01 shift left, 10 shift right, 11 parallel load
//   amt      - shift count, 0 means WIDTH shifts
//   rot      - rotate instead of serial fill for shift commands
//   fill     - serial fill bit when rot=0
//   din      - parallel load data
//   reg_q    - present value of the controlled register
//   s        - register mode: 00 hold, 01 left, 10 right, 11 load (registered)
//   r        - serial input to the register (combinational)
//   ld_data  - parallel data to the register (registered)
//   busy     - high while a load or shift is being issued (registered)
//   done     - one-cycle completion pulse (registered)
//   remain   - shifts still to be issued (registered)
module shift_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       cmd,
  input  logic [2:0]       amt,
  input  logic             rot,
  input  logic             fill,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] reg_q,
  output logic [1:0]       s,
  output logic             r,
  output logic [WIDTH-1:0] ld_data,
  output logic             busy,
  output logic             done,
  output logic [3:0]       remain
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [1:0]         s_nxt;
  logic [WIDTH-1:0]   ld_nxt;
  logic               busy_nxt, done_nxt;
  logic [CNT_W-1:0]   remain_nxt;
  logic               left_q, left_nxt;
  logic               rot_q, rot_nxt;
  logic               fill_q, fill_nxt;

  // Only the end bits of the register feed the rotate path.
  logic unused_reg_bits;
  assign unused_reg_bits = ^reg_q;

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      s       <= 2'b00;
      ld_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      remain  <= '0;
      left_q  <= 1'b0;
      rot_q   <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      s       <= s_nxt;
      ld_data <= ld_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      remain  <= remain_nxt;
      left_q  <= left_nxt;
      rot_q   <= rot_nxt;
      fill_q  <= fill_nxt;
    end
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    state_nxt  = state;
    s_nxt      = 2'b00;
    ld_nxt     = ld_data;
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;
    remain_nxt = remain;
    left_nxt   = left_q;
    rot_nxt    = rot_q;
    fill_nxt   = fill_q;

    unique case (state)
      IDLE: begin
        if (start) begin
          unique case (cmd)
            2'b11: begin
              ld_nxt    = din;
              s_nxt     = 2'b11;
              busy_nxt  = 1'b1;
              state_nxt = LOAD;
            end
            2'b01, 2'b10: begin
              left_nxt   = (cmd == 2'b01);
              rot_nxt    = rot;
              fill_nxt   = fill;
              remain_nxt = (amt == 3'd0) ? CNT_W'(WIDTH) : CNT_W'(amt);
              s_nxt      = cmd;
              busy_nxt   = 1'b1;
              state_nxt  = SHIFT;
            end
            default: begin
              done_nxt  = 1'b1;
              state_nxt = DONE;
            end
          endcase
        end
      end
      LOAD: begin
        done_nxt  = 1'b1;
        state_nxt = DONE;
      end
      SHIFT: begin
        remain_nxt = remain - CNT_W'(1);
        // The edge that retires the last shift goes straight to DONE.
        if (remain <= CNT_W'(1)) begin
          remain_nxt = '0;
          done_nxt   = 1'b1;
          state_nxt  = DONE;
        end else begin
          s_nxt    = left_q ? 2'b01 : 2'b10;
          busy_nxt = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Serial input: rotate feeds back the outgoing end bit, otherwise the latched fill.
  always_comb begin
    r = 1'b0;
    if (state == SHIFT) begin
      if (rot_q) r = left_q ? reg_q[WIDTH-1] : reg_q[0];
      else       r = fill_q;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: emulates the controlled register on the
// falling edge and checks handshake, timing and final register contents against an
// arithmetic model of each command.
module tb_shift_sequencer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   cmd;
  logic [2:0]   amt;
  logic         rot;
  logic         fill;
  logic [W-1:0] din;
  logic [W-1:0] reg_q;
  logic [1:0]   s;
  logic         r;
  logic [W-1:0] ld_data;
  logic         busy;
  logic         done;
  logic [3:0]   remain;

  int unsigned  n_cmp = 0;
  int unsigned  n_err = 0;
  logic [W-1:0] exp_ld;
  logic         preset_en = 1'b0;
  logic [W-1:0] preset_val = '0;

  shift_sequencer #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .cmd     (cmd),
    .amt     (amt),
    .rot     (rot),
    .fill    (fill),
    .din     (din),
    .reg_q   (reg_q),
    .s       (s),
    .r       (r),
    .ld_data (ld_data),
    .busy    (busy),
    .done    (done),
    .remain  (remain)
  );

  always #5 clk = ~clk;

  // Controlled register, sampling on the falling edge.
  always @(negedge clk) begin
    if (preset_en) reg_q <= preset_val;
    else begin
      case (s)
        2'b01:   reg_q <= {reg_q[W-2:0], r};
        2'b10:   reg_q <= {r, reg_q[W-1:1]};
        2'b11:   reg_q <= ld_data;
        default: reg_q <= reg_q;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected register contents after a whole command, from plain shift arithmetic.
  function automatic logic [W-1:0] model(input logic [1:0] c, input int n, input logic ro,
                                         input logic fi, input logic [W-1:0] r0,
                                         input logic [W-1:0] d);
    logic [2*W-1:0] v, mask, res;
    v    = {{W{1'b0}}, r0};
    mask = {{W{1'b0}}, {W{1'b1}}};
    res  = v;
    case (c)
      2'b11: res = {{W{1'b0}}, d};
      2'b01: res = ro ? ((v << n) | (v >> (W - n)))
                      : ((v << n) | (fi ? ((2*W)'(1) << n) - (2*W)'(1) : '0));
      2'b10: res = ro ? ((v >> n) | (v << (W - n)))
                      : ((v >> n) | (fi ? (mask & ~(mask >> n)) : '0));
      default: res = v;
    endcase
    return res[W-1:0];
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_s"}, s, 0);
    check({tag, "_r"}, r, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_remain"}, remain, 0);
    check({tag, "_ld"}, ld_data, exp_ld);
  endtask

  // Loads the emulated register while the sequencer is idle; ends at posedge+1.
  task automatic set_reg(input logic [W-1:0] v);
    preset_val = v;
    preset_en  = 1'b1;
    @(negedge clk);
    #1 preset_en = 1'b0;
    @(posedge clk); #1;
  endtask

  // Issues one command from IDLE (called at posedge+1) and checks every cycle
  // through DONE plus the following idle cycle; ends at posedge+1 in IDLE.
  task automatic run_cmd(input logic [1:0] c, input logic [2:0] a, input logic ro,
                         input logic fi, input logic [W-1:0] d, input bit noise);
    int n, len;
    logic [W-1:0] exp_reg;
    logic [1:0]   exp_s;
    logic         exp_r;
    n       = (a == 3'd0) ? W : int'(a);
    len     = (c == 2'b11) ? 1 : (c == 2'b00) ? 0 : n;
    exp_reg = model(c, n, ro, fi, reg_q, d);
    exp_s   = c;
    start = 1'b1; cmd = c; amt = a; rot = ro; fill = fi; din = d;
    @(posedge clk); #1;
    start = 1'b0;
    cmd = 2'($urandom); amt = 3'($urandom); rot = 1'($urandom);
    fill = 1'($urandom); din = W'($urandom);
    if (c == 2'b11) exp_ld = d;
    for (int i = 1; i <= len; i++) begin
      check("s", s, exp_s);
      check("busy", busy, 1);
      check("done", done, 0);
      check("remain", remain, (c == 2'b11) ? 0 : n - i + 1);
      check("ld_data", ld_data, exp_ld);
      if (c == 2'b11) exp_r = 1'b0;
      else if (ro) exp_r = (c == 2'b01) ? reg_q[W-1] : reg_q[0];
      else exp_r = fi;
      check("r", r, exp_r);
      if (noise && $urandom_range(0, 2) == 0) begin
        start = 1'b1; cmd = 2'($urandom); din = W'($urandom); amt = 3'($urandom);
      end else start = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("done_s", s, 0);
    check("done_busy", busy, 0);
    check("done_pulse", done, 1);
    check("done_remain", remain, 0);
    check("done_ld", ld_data, exp_ld);
    check("done_r", r, 0);
    check("reg_final", reg_q, exp_reg);
    // A start while done is high must be ignored.
    start = 1'b1; cmd = 2'($urandom); din = W'($urandom); amt = 3'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    check_quiet("after_done");
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; cmd = '0; amt = '0; rot = 1'b0; fill = 1'b0; din = '0;
    exp_ld = '0;
    #3;
    check_quiet("reset");
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_quiet("post_reset");

    // Parallel load of 0xA5.
    set_reg('0);
    run_cmd(2'b11, 3'd0, 1'b0, 1'b0, 8'hA5, 1'b0);
    check("load_reg", reg_q, 8'hA5);
    check("load_ld", ld_data, 8'hA5);

    // Shift left by 3 with fill=1 from 0x81.
    set_reg(8'h81);
    run_cmd(2'b01, 3'd3, 1'b0, 1'b1, 8'h00, 1'b0);
    check("shl3_reg", reg_q, 8'h0F);

    // Rotate right by WIDTH returns the original value.
    set_reg(8'h96);
    run_cmd(2'b10, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0);
    check("rotr8_reg", reg_q, 8'h96);

    // Starts pulsed during a 5-shift command are ignored.
    set_reg(8'h3C);
    run_cmd(2'b01, 3'd5, 1'b1, 1'b0, 8'h00, 1'b1);
    check("busy_rej_ld", ld_data, 8'hA5);

    // Nop, then back-to-back acceptance from IDLE.
    run_cmd(2'b00, 3'd4, 1'b0, 1'b0, 8'hFF, 1'b0);
    run_cmd(2'b11, 3'd0, 1'b0, 1'b0, 8'h5A, 1'b0);

    // Reset after 2 of 6 shifts aborts with everything zeroed at once.
    set_reg(8'hC3);
    start = 1'b1; cmd = 2'b10; amt = 3'd6; rot = 1'b0; fill = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", busy, 1);
    check("abort_remain", remain, 5);
    @(negedge clk); #1;
    reset = 1'b0;
    exp_ld = '0;
    #1;
    check_quiet("abort");
    repeat (2) begin
      @(posedge clk); #1;
      check_quiet("abort_hold");
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check_quiet("abort_release");
    run_cmd(2'b11, 3'd0, 1'b0, 1'b0, 8'h69, 1'b0);

    // Random commands with random noise starts.
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 3) == 0) set_reg(W'($urandom));
      run_cmd(2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), W'($urandom), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
